// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide responder.
//   - Op codes used by the D-stage decoder, the E stage and md_unit.
//   - Default busy latencies for multiply and divide.
//   - md_res_t: a computed HI/LO pair plus a write-enable. The write-enable
//     is cleared when the divisor is zero so that HI/LO keep their values.
//   - Small helpers that classify op codes.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
  } md_res_t;

  function automatic logic md_is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
//   Computes the HI/LO pair for one mult/multu/div/divu request.
// Ports:
//   op_i   [2:0]  operation code (md_pkg codes)
//   a_i    [31:0] rs operand (multiplicand / dividend)
//   b_i    [31:0] rt operand (multiplier / divisor)
//   res_o         md_res_t {hi, lo, we}; we=0 for a zero divisor or for
//                 any op that is not a multiply or divide.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_res_t     res_o
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        b_sdiv;
  logic [31:0]        b_udiv;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  assign div_zero = (b_i == 32'd0);
  assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // The divider never sees a zero divisor or the signed overflow pair.
  // Substituting 1 for the overflow case yields exactly the required
  // answer (quotient 0x80000000, remainder 0) with no special mux.
  assign b_sdiv = (div_zero || div_ovf) ? 32'd1 : b_i;
  assign b_udiv = div_zero ? 32'd1 : b_i;

  // SV signed division truncates toward zero and the remainder takes
  // the dividend's sign, matching MIPS div semantics.
  assign quo_s = $signed(a_i) / $signed(b_sdiv);
  assign rem_s = $signed(a_i) % $signed(b_sdiv);
  assign quo_u = a_i / b_udiv;
  assign rem_u = a_i % b_udiv;

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT: begin
        res_o.hi = prod_s[63:32];
        res_o.lo = prod_s[31:0];
        res_o.we = 1'b1;
      end
      MD_MULTU: begin
        res_o.hi = prod_u[63:32];
        res_o.lo = prod_u[31:0];
        res_o.we = 1'b1;
      end
      MD_DIV: begin
        res_o.hi = rem_s;
        res_o.lo = quo_s;
        res_o.we = !div_zero;
      end
      MD_DIVU: begin
        res_o.hi = rem_u;
        res_o.lo = quo_u;
        res_o.we = !div_zero;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide responder holding the architectural HI/LO.
//   Accepts one request per IDLE cycle, models a fixed multi-cycle
//   latency for mult/div, and updates HI/LO only on completion.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | ready; start is sampled, mthi/mtlo write immediately
//   RUN   | mult/div in flight; counter runs down, start is ignored
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high
//   start          request valid (sampled only in IDLE)
//   op      [2:0]  md_pkg op code
//   rs_val  [31:0] rs operand / mthi-mtlo source
//   rt_val  [31:0] rt operand
//   busy           operation in flight
//   pending        start | busy, for the D-stage hazard unit
//   hi      [31:0] architectural HI
//   lo      [31:0] architectural LO
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        pending,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  md_res_t          res_q, res_d;
  md_res_t          arith_res;

  // The result is computed from the operands present at the start edge
  // and held in res_q, so operand changes during RUN cannot leak in.
  md_arith u_arith (
    .op_i  (op),
    .a_i   (rs_val),
    .b_i   (rt_val),
    .res_o (arith_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (md_is_mult(op) || md_is_div(op)) begin
            res_d   = arith_res;
            cnt_d   = md_is_div(op) ? DIV_LOAD : MULT_LOAD;
            state_d = ST_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // A zero divisor clears res_q.we, leaving HI/LO untouched.
          if (res_q.we) begin
            hi_d = res_q.hi;
            lo_d = res_q.lo;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign pending = start | busy;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  localparam int LAT_MULT = 5;
  localparam int LAT_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic        pending;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic allow_viol = 1'b0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  md_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .pending (pending),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // start during RUN is a protocol violation except where a test does it on purpose
  always @(posedge clk) begin
    if (!reset && !allow_viol && start && busy) begin
      failures++;
      $display("FAIL start_while_busy actual=1 expected=0");
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    lat = 0;
    case (o)
      MD_MULT: begin
        q = sa * sb;
        hi_m = 32'(q >>> 32);
        lo_m = 32'(q);
        lat = LAT_MULT;
      end
      MD_MULTU: begin
        uq = ua * ub;
        hi_m = 32'(uq >> 32);
        lo_m = 32'(uq);
        lat = LAT_MULT;
      end
      MD_DIV: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          lo_m = 32'(q);
          hi_m = 32'(r);
        end
        lat = LAT_DIV;
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          uq = ua / ub;
          ur = ua % ub;
          lo_m = 32'(uq);
          hi_m = 32'(ur);
        end
        lat = LAT_DIV;
      end
      MD_MTHI: hi_m = a;
      MD_MTLO: lo_m = a;
      default: lat = 0;
    endcase
  endtask

  // Issue one request at a negedge, then count busy cycles and check HI/LO.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] eh, input logic [31:0] el,
                       input string nm);
    int n;
    int drops;
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    #1;
    chk({nm, " pending_at_start"}, 64'(pending), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
    n = 0;
    drops = 0;
    while (busy && n < 200) begin
      if (!pending) drops++;
      n++;
      @(posedge clk);
      #1;
    end
    chk({nm, " busy_cycles"}, 64'(n), 64'(exp_lat));
    chk({nm, " pending_drops"}, 64'(drops), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, n, drops;
    logic [2:0]  o;
    logic [31:0] a, b, h1, l1, lo_before;

    vecs[0] = '{MD_MULT,  32'd7,          32'hFFFF_FFFD, LAT_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7x-3"};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF,  32'd2,         LAT_MULT, 32'h0000_0001, 32'hFFFF_FFFE, "multu_max_x2"};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         LAT_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_-7/2"};
    vecs[3] = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, LAT_DIV,  32'h0000_0000, 32'h8000_0000, "div_ovf"};
    vecs[4] = '{MD_MTHI,  32'h0000_0011,  32'd0,         0,        32'h0000_0011, 32'h8000_0000, "mthi"};
    vecs[5] = '{MD_MTLO,  32'h0000_0022,  32'd0,         0,        32'h0000_0011, 32'h0000_0022, "mtlo"};
    vecs[6] = '{MD_DIVU,  32'd7,          32'd0,         LAT_DIV,  32'h0000_0011, 32'h0000_0022, "divu_by_zero"};
    vecs[7] = '{3'd7,     32'h0000_0055,  32'd3,         0,        32'h0000_0011, 32'h0000_0022, "invalid_op"};
    vecs[8] = '{MD_DIVU,  32'h8000_0000,  32'hFFFF_FFFF, LAT_DIV,  32'h8000_0000, 32'h0000_0000, "divu_big"};

    // reset state
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset pending", 64'(pending), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed table
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].name);
      hi_m = vecs[i].hi;
      lo_m = vecs[i].lo;
    end

    // randomized against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      model_exec(o, a, b, lat);
      issue(o, a, b, lat, hi_m, lo_m, "rand");
    end

    // start(mtlo) during the 3rd busy cycle of a mult is ignored
    lo_before = lo_m;
    a = 32'h1234_5678;
    b = 32'h0000_9ABC;
    model_exec(MD_MULT, a, b, lat);
    @(negedge clk);
    start = 1'b1; op = MD_MULT; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    allow_viol = 1'b1;
    start = 1'b1; op = MD_MTLO; rs_val = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    allow_viol = 1'b0;
    chk("ignored_mtlo lo_during_run", 64'(lo), 64'(lo_before));
    chk("ignored_mtlo still_busy", 64'(busy), 64'd1);
    n = 3;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("ignored_mtlo busy_cycles", 64'(n), 64'(LAT_MULT));
    chk("ignored_mtlo hi", 64'(hi), 64'(hi_m));
    chk("ignored_mtlo lo", 64'(lo), 64'(lo_m));

    // back-to-back mults: second start in the cycle busy falls
    a = $urandom; b = $urandom;
    model_exec(MD_MULT, a, b, lat);
    h1 = hi_m; l1 = lo_m;
    @(negedge clk);
    start = 1'b1; op = MD_MULT; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; drops = 0;
    while (busy && n < 200) begin
      if (!pending) drops++;
      n++;
      @(posedge clk); #1;
    end
    chk("b2b first busy_cycles", 64'(n), 64'(LAT_MULT));
    chk("b2b first hi", 64'(hi), 64'(h1));
    chk("b2b first lo", 64'(lo), 64'(l1));
    a = $urandom; b = $urandom;
    model_exec(MD_MULT, a, b, lat);
    start = 1'b1; op = MD_MULT; rs_val = a; rt_val = b;
    #1;
    if (!pending) drops++;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b second accepted", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 200) begin
      if (!pending) drops++;
      n++;
      @(posedge clk); #1;
    end
    chk("b2b second busy_cycles", 64'(n), 64'(LAT_MULT));
    chk("b2b pending_drops", 64'(drops), 64'd0);
    chk("b2b second hi", 64'(hi), 64'(hi_m));
    chk("b2b second lo", 64'(lo), 64'(lo_m));

    // asynchronous reset mid-div
    @(negedge clk);
    start = 1'b1; op = MD_DIV; rs_val = 32'd1000; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset busy", 64'(busy), 64'd0);
    chk("async_reset hi", 64'(hi), 64'd0);
    chk("async_reset lo", 64'(lo), 64'd0);
    chk("async_reset pending", 64'(pending), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    model_exec(MD_DIV, 32'd1000, 32'd7, lat);
    issue(MD_DIV, 32'd1000, 32'd7, lat, hi_m, lo_m, "after_reset_div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide responder for the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo requests issued from the E stage and holds the architectural HI/LO registers. It models fixed multi-cycle latency and drives the `busy` flag that the F/D stall logic consumes. The E stage is the initiator; this block is the only writer of HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be ≥1).

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `start`: input, 1 bit. Request valid this cycle; sampled only in IDLE.
- `op`: input, 3 bits. `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO` (codes in `md_pkg`).
- `rs_val`: input, 32 bits. Forwarded rs operand (dividend or multiplicand; mthi/mtlo source).
- `rt_val`: input, 32 bits. Forwarded rt operand (divisor or multiplier).
- `busy`: output, 1 bit. High while an operation is in flight.
- `pending`: output, 1 bit. Combinational `start | busy`. The hazard unit stalls any mfhi/mflo/md instruction in D while this is high.
- `hi`: output, 32 bits. Architectural HI.
- `lo`: output, 32 bits. Architectural LO.

## Operation
- States: IDLE and RUN.
- Reset, asynchronous, effective immediately: state=IDLE, busy=0, hi=0, lo=0, counter=0, result regs=0.
- IDLE with start and a mult/div op:
  - Latch op and operands.
  - Compute the result into internal `res_hi`/`res_lo`.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE with start and mthi/mtlo: write rs_val to hi or lo at the next edge. State stays IDLE, busy stays 0, the other register is untouched.
- RUN:
  - Counter decrements each cycle.
  - When counter==1, at that edge: hi←res_hi, lo←res_lo, state→IDLE.
- `start` while RUN: ignored, with no effect on state or results. This is a protocol violation; the bench flags it with an assertion.
- mult: signed 32×32→64; HI=upper word, LO=lower word.
- multu: unsigned 32×32→64; HI=upper word, LO=lower word.
- div:
  - Signed division; quotient truncates toward zero. LO=quotient, HI=remainder, and the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned division; LO=quotient, HI=remainder.
- Divisor zero (div or divu): the full busy period still runs; hi/lo keep their prior values at completion.
- Invalid op code with start: treated as no-op; the block stays IDLE.

## Timing
- `start` sampled at edge N.
- busy is high from cycle N+1 through N+L, where L = MULT_CYCLES or DIV_CYCLES.
- hi/lo take new values at the edge ending cycle N+L, so they are visible in cycle N+L+1, the same cycle busy falls.
- mthi/mtlo take new values at edge N and are visible in cycle N+1. busy never rises.
- Back-to-back: a new start is accepted in the first cycle busy is low. Minimum spacing between mult starts is L+1 cycles.
- pending is high in cycle N and throughout busy, so a dependent mfhi is stalled until the result is visible.
- Reset asserted mid-RUN: the operation is aborted, hi/lo=0, busy=0 immediately. No partial result is ever written.
- Operands are captured at the start edge. Changes to rs_val/rt_val during RUN have no effect.

## Structure
- `md_pkg` holds the op code localparams and the default latencies `MD_MULT_CYCLES` and `MD_DIV_CYCLES`. The D-stage decoder and E stage import the same codes.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Arithmetic (64-bit signed/unsigned product, signed/unsigned quotient and remainder with the overflow and zero special cases) goes in a combinational sub-module `md_arith`. The `md_unit` top holds only the FSM, counter and registers.

## Test plan
- After reset, `start`, op=mult, rs=7, rt=0xFFFFFFFD (−3): busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- op=multu, rs=0xFFFFFFFF, rt=2: hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- op=div, rs=0xFFFFFFF9 (−7), rt=2: busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via mthi/mtlo (busy stays 0; values visible next cycle). Then divu rs=7, rt=0: 10 busy cycles, hi=0x11, lo=0x22 unchanged.
- mult started. On the 3rd busy cycle, assert start with op=mtlo: ignored, and the final result is the mult result. Then assert reset asynchronously mid-div: busy=0, hi=lo=0 without waiting for a clock edge.
- Back-to-back: second mult issued in the cycle busy falls; it is accepted, and pending stays high continuously across both operations.
